// File: rtl/unidade_logica_aritmetica_multiciclo.sv
// Registered integer ALU for the iZero datapath: single-cycle logic/shift/move ops,
// iterative shift-add MUL and restoring DIV behind a start/ocupado/pronto handshake.
module unidade_logica_aritmetica_multiciclo #(
    parameter  int WIDTH   = 32,
    localparam int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         aluOp,
    input  logic               sinal,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHIFT_W-1:0] shift,
    output logic [WIDTH-1:0]   resultado,
    output logic [WIDTH-1:0]   resto,
    output logic               maior,
    output logic               igual,
    output logic               menor,
    output logic               div_zero,
    output logic               ocupado,
    output logic               pronto
);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] CONCLUI = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_PASA = 4'b1010;
    localparam logic [3:0] OP_PASB = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;

    localparam logic [SHIFT_W:0] CONT_INI = (SHIFT_W + 1)'(WIDTH);
    localparam logic [SHIFT_W:0] CONT_UM  = (SHIFT_W + 1)'(1);

    logic [1:0]         estado;
    logic [SHIFT_W:0]   contador;
    logic               eh_div;
    logic               sinal_r;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   mb;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   acc;

    logic               eh_multi;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     soma;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     dif;
    logic [2*WIDTH-1:0] produto;
    logic [WIDTH-1:0]   quociente;
    logic [WIDTH-1:0]   resto_div;
    logic [WIDTH-1:0]   simples;

    // {maior, igual, menor}; exactly one bit is set.
    function automatic logic [2:0] comparar(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic s);
        logic lt;
        lt = s ? ($signed(x) < $signed(y)) : (x < y);
        if (x == y)
            return 3'b010;
        else if (lt)
            return 3'b001;
        else
            return 3'b100;
    endfunction

    assign eh_multi = (aluOp == OP_MUL) || (aluOp == OP_DIV);
    assign mag_a    = (sinal && A[WIDTH-1]) ? -A : A;
    assign mag_b    = (sinal && B[WIDTH-1]) ? -B : B;

    // acc:q is the running product (mul) or partial remainder:dividend (div).
    assign soma      = {1'b0, acc} + (q[0] ? {1'b0, mb} : '0);
    assign r_sh      = {acc, q[WIDTH-1]};
    assign dif       = r_sh - {1'b0, mb};
    assign produto   = neg_q ? -{acc, q} : {acc, q};
    assign quociente = neg_q ? -q : q;
    assign resto_div = neg_r ? -acc : acc;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        simples = '0;
        case (aluOp)
            OP_ADD:  simples = A + B;
            OP_SUB:  simples = A - B;
            OP_AND:  simples = A & B;
            OP_OR:   simples = A | B;
            OP_XOR:  simples = A ^ B;
            OP_NOT:  simples = ~A;
            OP_SLL:  simples = A << shift;
            OP_SRL:  simples = A >> shift;
            OP_SRA:  simples = $signed(A) >>> shift;
            OP_PASA: simples = A;
            OP_PASB: simples = B;
            default: simples = '0;
        endcase
    end

    // NOTE: state uses non-blocking assignments only; the synchronous reset also clears the
    // datapath registers so a reset mid-operation leaves nothing stale behind.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado    <= OCIOSO;
            contador  <= '0;
            eh_div    <= 1'b0;
            sinal_r   <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            mb        <= '0;
            q         <= '0;
            acc       <= '0;
            resultado <= '0;
            resto     <= '0;
            maior     <= 1'b0;
            igual     <= 1'b0;
            menor     <= 1'b0;
            div_zero  <= 1'b0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (start && eh_multi) begin
                        estado   <= CALC;
                        contador <= CONT_INI;
                        ocupado  <= 1'b1;
                        eh_div   <= (aluOp == OP_DIV);
                        sinal_r  <= sinal;
                        a_r      <= A;
                        b_r      <= B;
                        mb       <= mag_b;
                        q        <= mag_a;
                        acc      <= '0;
                        neg_q    <= sinal & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r    <= sinal & A[WIDTH-1];
                    end else if (start) begin
                        resultado               <= simples;
                        resto                   <= '0;
                        {maior, igual, menor}   <= comparar(A, B, sinal);
                        div_zero                <= 1'b0;
                        pronto                  <= 1'b1;
                    end
                end
                CALC: begin
                    contador <= contador - CONT_UM;
                    if (contador == CONT_UM)
                        estado <= CONCLUI;
                    if (eh_div) begin
                        // Restoring step: keep the subtraction only when it did not go negative.
                        if (!dif[WIDTH]) begin
                            acc <= dif[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= r_sh[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= soma[WIDTH:1];
                        q   <= {soma[0], q[WIDTH-1:1]};
                    end
                end
                CONCLUI: begin
                    estado                <= OCIOSO;
                    ocupado               <= 1'b0;
                    pronto                <= 1'b1;
                    {maior, igual, menor} <= comparar(a_r, b_r, sinal_r);
                    if (!eh_div) begin
                        {resto, resultado} <= produto;
                        div_zero           <= 1'b0;
                    end else if (b_r == '0) begin
                        resultado <= '1;
                        resto     <= a_r;
                        div_zero  <= 1'b1;
                    end else begin
                        resultado <= quociente;
                        resto     <= resto_div;
                        div_zero  <= 1'b0;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_logica_aritmetica_multiciclo.sv
// Randomized self-checking bench for the multi-cycle ALU against an arithmetic reference model.
module tb_unidade_logica_aritmetica_multiciclo;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  aluOp;
    logic        sinal;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shift;
    logic [31:0] resultado;
    logic [31:0] resto;
    logic        maior;
    logic        igual;
    logic        menor;
    logic        div_zero;
    logic        ocupado;
    logic        pronto;

    int tests = 0;
    int fails = 0;
    int lat;
    int busy;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] hi;
        logic [3:0]  flags; // {maior, igual, menor, div_zero}
    } ref_t;

    unidade_logica_aritmetica_multiciclo #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .aluOp(aluOp), .sinal(sinal),
        .A(A), .B(B), .shift(shift), .resultado(resultado), .resto(resto),
        .maior(maior), .igual(igual), .menor(menor), .div_zero(div_zero),
        .ocupado(ocupado), .pronto(pronto)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ref_t model(input logic [3:0] op, input logic s, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        ref_t m;
        logic signed [31:0] sa;
        longint prod_s;
        logic [63:0] prod_u;
        int ia;
        int ib;
        m = '0;
        sa = a;
        ia = a;
        ib = b;
        case (op)
            4'b0000: m.r = a + b;
            4'b0001: m.r = a - b;
            4'b0100: m.r = a & b;
            4'b0101: m.r = a | b;
            4'b0110: m.r = a ^ b;
            4'b0111: m.r = ~a;
            4'b1000: m.r = a << sh;
            4'b1001: m.r = a >> sh;
            4'b1100: m.r = sa >>> sh;
            4'b1010: m.r = a;
            4'b1011: m.r = b;
            4'b0010: begin
                if (s) begin
                    prod_s = longint'(ia) * longint'(ib);
                    {m.hi, m.r} = prod_s;
                end else begin
                    prod_u = {32'h0, a} * {32'h0, b};
                    {m.hi, m.r} = prod_u;
                end
            end
            4'b0011: begin
                if (b == 32'h0) begin
                    m.r = 32'hFFFF_FFFF;
                    m.hi = a;
                    m.flags[0] = 1'b1;
                end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m.r = 32'h8000_0000;
                    m.hi = 32'h0;
                end else if (s) begin
                    m.r = ia / ib;
                    m.hi = ia % ib;
                end else begin
                    m.r = a / b;
                    m.hi = a % b;
                end
            end
            default: m.r = 32'h0;
        endcase
        if (a == b)
            m.flags[3:1] = 3'b010;
        else if (s ? (ia < ib) : (a < b))
            m.flags[3:1] = 3'b001;
        else
            m.flags[3:1] = 3'b100;
        return m;
    endfunction

    // Issues one op, waits for pronto (bounded), and checks latency and all results.
    // poke != 0 pulses an ADD 1+1 start in that cycle of a running op.
    task automatic run_op(input logic [3:0] op, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input string tag,
                          input int poke);
        ref_t m;
        bit multi;
        multi = (op == 4'b0010) || (op == 4'b0011);
        m = model(op, s, a, b, sh);
        aluOp = op; sinal = s; A = a; B = b; shift = sh; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        A = $urandom; B = $urandom; aluOp = 4'($urandom); sinal = 1'($urandom); shift = 5'($urandom);
        @(negedge clock);
        lat = 1;
        busy = 0;
        while (!pronto && lat < 100) begin
            busy += int'(ocupado);
            start = 1'b0;
            if (poke != 0 && lat == poke) begin
                aluOp = 4'b0000; sinal = 1'b0; A = 32'd1; B = 32'd1; start = 1'b1;
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(lat), multi ? 64'd34 : 64'd1);
        check({tag, ".busy"}, 64'(busy), multi ? 64'd33 : 64'd0);
        check({tag, ".resultado"}, 64'(resultado), 64'(m.r));
        check({tag, ".resto"}, 64'(resto), 64'(m.hi));
        check({tag, ".flags"}, 64'({maior, igual, menor, div_zero}), 64'(m.flags));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int hits;
        reset = 1'b0; start = 1'b0; aluOp = '0; sinal = 1'b0; A = '0; B = '0; shift = '0;
        repeat (2) @(negedge clock);
        check("reset.data", {resultado, resto}, 64'h0);
        check("reset.ctrl", 64'({maior, igual, menor, div_zero, ocupado, pronto}), 64'h0);
        reset = 1'b1;
        @(negedge clock);

        run_op(4'b0000, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd0, "add_wrap", 0);
        check("add_wrap.const", 64'(resultado), 64'h8000_0000);
        run_op(4'b0010, 1'b1, 32'hFFFF_FFFD, 32'd7, 5'd0, "mul_signed", 0);
        check("mul_signed.const", {resto, resultado}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(4'b0011, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd0, "div_signed", 0);
        check("div_signed.const", {resto, resultado}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'b0011, 1'b0, 32'd100, 32'd0, 5'd0, "div_zero", 0);
        check("div_zero.flag", 64'(div_zero), 64'h1);
        run_op(4'b0011, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, "div_min", 0);
        run_op(4'b1100, 1'b0, 32'h8000_0000, 32'h0, 5'd4, "sra", 0);
        check("sra.const", 64'(resultado), 64'hF800_0000);
        run_op(4'b1001, 1'b0, 32'h8000_0000, 32'h0, 5'd4, "srl", 0);
        run_op(4'b1000, 1'b0, 32'h1234_5678, 32'h0, 5'd0, "sll0", 0);
        run_op(4'b0000, 1'b1, 32'hFFFF_FFFF, 32'h1, 5'd0, "cmp_signed", 0);
        check("cmp_signed.menor", 64'(menor), 64'h1);
        run_op(4'b0000, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, "cmp_unsigned", 0);
        check("cmp_unsigned.maior", 64'(maior), 64'h1);

        // Start during a DIV is dropped; an ADD issued in the pronto cycle is taken.
        run_op(4'b0011, 1'b0, 32'd1000, 32'd7, 5'd0, "div_busy_start", 5);
        run_op(4'b0000, 1'b0, 32'd1, 32'd1, 5'd0, "add_back2back", 0);
        @(negedge clock);
        check("pronto_pulse", 64'(pronto), 64'h0);

        // Reset in cycle 10 of a MUL aborts it with no pronto.
        run_op(4'b0000, 1'b0, 32'd3, 32'd4, 5'd0, "add_pre_reset", 0);
        aluOp = 4'b0010; sinal = 1'b0; A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset.data", {resultado, resto}, 64'h0);
        check("midreset.ctrl", 64'({maior, igual, menor, div_zero, ocupado, pronto}), 64'h0);
        reset = 1'b1;
        hits = 0;
        repeat (40) begin
            @(negedge clock);
            hits += int'(pronto) + int'(ocupado);
        end
        check("midreset.no_pronto", 64'(hits), 64'h0);
        run_op(4'b0010, 1'b0, 32'd5, 32'd6, 5'd0, "mul_after_reset", 0);
        check("mul_after_reset.const", 64'(resultado), 64'd30);

        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), 1'($urandom), pick(), pick(), 5'($urandom),
                   $sformatf("rand%0d", i), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
